uart_rx_deframer: RTL and testbench

- 8N1 UART receiver that brings the board's RX pin into the core clock domain and deframes serial bytes.
- Pairs with the existing core-driven TX path, which it mirrors in the receive direction.
- Delivers each byte through a one-entry valid/ready holding register.
- Reports framing errors and overruns as single-cycle pulses for status/interrupt logic.

---
 rtl/uart_rx_deframer.sv | 161 ++++++++++++++++
 tb/tb_uart_rx_deframer.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_deframer.sv
// 8N1 UART receiver: two-flop synchronizer, mid-bit sampling deframer FSM and a
// one-entry valid/ready holding register with framing-error and overrun pulses.
module uart_rx_deframer #(
  parameter int CLKS_PER_BIT = 556,
  parameter int HALF_BIT     = CLKS_PER_BIT / 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_uart_rx,
  output logic [7:0] o_data,
  output logic       o_valid,
  input  logic       i_ready,
  output logic       o_frame_err,
  output logic       o_overrun,
  output logic       o_busy
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] CNT_ONE       = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_HALF_LAST = CNT_W'(HALF_BIT - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP
  } state_e;

  logic             rx_meta_q;
  logic             rx_s_q;
  state_e           state_q,     state_d;
  logic [CNT_W-1:0] cnt_q,       cnt_d;
  logic [2:0]       bit_idx_q,   bit_idx_d;
  logic [7:0]       shift_q,     shift_d;
  logic             byte_rdy_q,  byte_rdy_d;
  logic             frame_err_q, frame_err_d;
  logic [7:0]       data_q,      data_d;
  logic             valid_q,     valid_d;
  logic             overrun_q,   overrun_d;

  // Synchronizer: idle-high line, so both flops reset to 1
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
    end else begin
      rx_meta_q <= i_uart_rx;
      rx_s_q    <= rx_meta_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      bit_idx_q   <= '0;
      shift_q     <= '0;
      byte_rdy_q  <= 1'b0;
      frame_err_q <= 1'b0;
      data_q      <= '0;
      valid_q     <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bit_idx_q   <= bit_idx_d;
      shift_q     <= shift_d;
      byte_rdy_q  <= byte_rdy_d;
      frame_err_q <= frame_err_d;
      data_q      <= data_d;
      valid_q     <= valid_d;
      overrun_q   <= overrun_d;
    end
  end

  // Deframer: the counter is cleared at every sample point, so it never wraps
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    bit_idx_d   = bit_idx_q;
    shift_d     = shift_q;
    byte_rdy_d  = 1'b0;
    frame_err_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!rx_s_q) begin
          state_d = S_START;
          cnt_d   = '0;
        end
      end
      S_START: begin
        if (cnt_q == CNT_HALF_LAST) begin
          cnt_d = '0;
          if (rx_s_q) begin
            state_d = S_IDLE;
          end else begin
            state_d   = S_DATA;
            bit_idx_d = '0;
          end
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      S_DATA: begin
        if (cnt_q == CNT_BIT_LAST) begin
          shift_d   = {rx_s_q, shift_q[7:1]};
          cnt_d     = '0;
          bit_idx_d = bit_idx_q + 3'd1;
          if (bit_idx_q == 3'd7) begin
            state_d = S_STOP;
          end
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      S_STOP: begin
        // Leaving at mid-stop lets a back-to-back start edge be seen at once
        if (cnt_q == CNT_BIT_LAST) begin
          cnt_d   = '0;
          state_d = S_IDLE;
          if (rx_s_q) begin
            byte_rdy_d = 1'b1;
          end else begin
            frame_err_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Holding register: a consume on the load edge frees the slot for the new byte
  always_comb begin
    data_d    = data_q;
    valid_d   = valid_q;
    overrun_d = 1'b0;
    if (byte_rdy_q) begin
      if (!valid_q || i_ready) begin
        data_d  = shift_q;
        valid_d = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end else if (valid_q && i_ready) begin
      valid_d = 1'b0;
    end
  end

  assign o_data      = data_q;
  assign o_valid     = valid_q;
  assign o_frame_err = frame_err_q;
  assign o_overrun   = overrun_q;
  assign o_busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_rx_deframer.sv
// Bench for uart_rx_deframer: frame-level reference model predicts load edges from
// frame start times and tracks the holding register against randomized traffic.
module tb_uart_rx_deframer;

  localparam int C   = 16;
  localparam int H   = C / 2;
  localparam int LAT = 3 + H + 9 * C;

  logic       clk;
  logic       rst_n;
  logic       i_uart_rx;
  logic [7:0] o_data;
  logic       o_valid;
  logic       i_ready;
  logic       o_frame_err;
  logic       o_overrun;
  logic       o_busy;

  uart_rx_deframer #(.CLKS_PER_BIT(C)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_uart_rx  (i_uart_rx),
    .o_data     (o_data),
    .o_valid    (o_valid),
    .i_ready    (i_ready),
    .o_frame_err(o_frame_err),
    .o_overrun  (o_overrun),
    .o_busy     (o_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;

  logic [7:0] offer [int];
  int  ferr_exp  = 0;
  int  ferr_seen = 0;
  int  ovr_seen  = 0;
  bit  rand_rdy  = 1'b0;

  logic [7:0] m_data  = 8'h00;
  logic       m_valid = 1'b0;
  logic       m_ovr   = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Reference: per edge, apply frame arrivals and consumer handshakes to the holding register
  initial begin
    logic rdy_e;
    logic rst_e;
    logic prev_ferr;
    prev_ferr = 1'b0;
    forever begin
      @(posedge clk);
      cyc++;
      rdy_e = i_ready;
      rst_e = rst_n;
      @(negedge clk);
      if (!rst_n || !rst_e) begin
        m_data  = 8'h00;
        m_valid = 1'b0;
        m_ovr   = 1'b0;
        offer.delete();
        prev_ferr = 1'b0;
        chk("rst_valid", o_valid, 0);
        chk("rst_data", o_data, 0);
        chk("rst_ferr", o_frame_err, 0);
        chk("rst_ovr", o_overrun, 0);
        chk("rst_busy", o_busy, 0);
      end else begin
        m_ovr = 1'b0;
        if (offer.exists(cyc)) begin
          if (!m_valid || rdy_e) begin
            m_data  = offer[cyc];
            m_valid = 1'b1;
          end else begin
            m_ovr = 1'b1;
          end
          offer.delete(cyc);
        end else if (m_valid && rdy_e) begin
          m_valid = 1'b0;
        end
        chk("valid", o_valid, m_valid);
        chk("data", o_data, m_data);
        chk("overrun", o_overrun, m_ovr);
        chk("err_overlap", o_frame_err && o_overrun, 0);
        chk("ferr_width", o_frame_err && prev_ferr, 0);
        if (o_frame_err) ferr_seen++;
        if (o_overrun) ovr_seen++;
        prev_ferr = o_frame_err;
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
      if (rand_rdy) i_ready = 1'($urandom_range(0, 1));
    end
  endtask

  // Drives one frame; the edge after this call is cycle 0 of the frame
  task automatic send_frame(input logic [7:0] b, input bit stop_ok, input bit rdy_pulse,
                            input int abort_bit);
    int e;
    e = cyc + 1;
    if (abort_bit < 0) begin
      if (stop_ok) offer[e + LAT] = b;
      else ferr_exp++;
    end
    i_uart_rx = 1'b0;
    tick(C);
    for (int i = 0; i < 8; i++) begin
      i_uart_rx = b[i];
      if (i == abort_bit) begin
        tick(H);
        rst_n = 1'b0;
        tick(3);
        i_uart_rx = 1'b1;
        rst_n = 1'b1;
        return;
      end
      tick(C);
    end
    i_uart_rx = stop_ok;
    if (rdy_pulse) begin
      tick(11);
      i_ready = 1'b1;
      tick(1);
      i_ready = 1'b0;
      tick(C - 12);
    end else begin
      tick(C);
    end
    i_uart_rx = 1'b1;
  endtask

  initial begin
    int ovr_base;
    int gap;
    logic [7:0] rb;
    bit ok;
    rst_n     = 1'b0;
    i_uart_rx = 1'b1;
    i_ready   = 1'b0;
    tick(4);
    rst_n = 1'b1;
    tick(4);

    // Single byte with consumer stalled, then accepted
    send_frame(8'h55, 1'b1, 1'b0, -1);
    chk("single_valid", o_valid, 1);
    chk("single_data", o_data, 8'h55);
    i_ready = 1'b1;
    tick(1);
    chk("single_clear", o_valid, 0);
    chk("single_hold", o_data, 8'h55);
    tick(5);

    // Back-to-back frames, consumer always ready
    send_frame(8'hA5, 1'b1, 1'b0, -1);
    send_frame(8'h3C, 1'b1, 1'b0, -1);
    tick(2 * C);
    chk("b2b_ferr", ferr_seen, 0);

    // Glitch shorter than half a bit
    i_ready = 1'b0;
    i_uart_rx = 1'b0;
    tick(5);
    i_uart_rx = 1'b1;
    chk("glitch_busy_hi", o_busy, 1);
    tick(H);
    chk("glitch_busy_lo", o_busy, 0);
    tick(C);
    chk("glitch_valid", o_valid, 0);
    chk("glitch_ferr", ferr_seen, 0);

    // Framing error, then a good frame
    send_frame(8'hF0, 1'b0, 1'b0, -1);
    tick(2 * C);
    chk("ferr_count", ferr_seen, 1);
    chk("ferr_valid", o_valid, 0);
    send_frame(8'h12, 1'b1, 1'b0, -1);
    tick(4);
    chk("after_ferr_data", o_data, 8'h12);
    chk("after_ferr_valid", o_valid, 1);
    i_ready = 1'b1;
    tick(2);
    i_ready = 1'b0;

    // Overrun with consumer stalled
    ovr_base = ovr_seen;
    send_frame(8'h11, 1'b1, 1'b0, -1);
    send_frame(8'h22, 1'b1, 1'b0, -1);
    tick(4);
    chk("ovr_pulse", ovr_seen - ovr_base, 1);
    chk("ovr_data", o_data, 8'h11);
    chk("ovr_valid", o_valid, 1);
    i_ready = 1'b1;
    tick(1);
    i_ready = 1'b0;

    // Consume on the load edge: new byte replaces old, no overrun
    ovr_base = ovr_seen;
    send_frame(8'h11, 1'b1, 1'b0, -1);
    send_frame(8'h22, 1'b1, 1'b1, -1);
    tick(4);
    chk("accept_data", o_data, 8'h22);
    chk("accept_valid", o_valid, 1);
    chk("accept_no_ovr", ovr_seen - ovr_base, 0);
    i_ready = 1'b1;
    tick(2);
    i_ready = 1'b0;

    // Reset during bit 4, then a fresh frame
    send_frame(8'h81, 1'b1, 1'b0, 4);
    chk("rst_mid_valid", o_valid, 0);
    chk("rst_mid_data", o_data, 0);
    chk("rst_mid_busy", o_busy, 0);
    tick(2 * C);
    chk("rst_mid_stale", o_valid, 0);
    send_frame(8'h7E, 1'b1, 1'b0, -1);
    tick(4);
    chk("post_rst_data", o_data, 8'h7E);
    chk("post_rst_valid", o_valid, 1);
    chk("ferr_total_dir", ferr_seen, ferr_exp);

    // Randomized traffic with random consumer backpressure
    rand_rdy = 1'b1;
    for (int k = 0; k < 30; k++) begin
      rb = 8'($urandom_range(0, 255));
      ok = ($urandom_range(0, 5) != 0);
      send_frame(rb, ok, 1'b0, -1);
      gap = ok ? int'($urandom_range(0, 20)) : C + int'($urandom_range(0, 10));
      tick(gap);
    end
    rand_rdy = 1'b0;
    i_ready = 1'b1;
    tick(2 * C);
    chk("ferr_total_rand", ferr_seen, ferr_exp);
    chk("offers_drained", offer.num(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
